// File: rtl/snake_pkg.sv
// Shared constants and state encoding for the snake game's VGA-side blocks.
package snake_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } plot_state_e;

  // Round-robin successor of a port index, wrapping modulo n.
  function automatic int next_port(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/screen_clear_sweeper.sv
// Raster counters for the full-screen sweep: tracks the pixel currently on the
// VGA port and offers its raster successor plus a last-pixel flag.
module screen_clear_sweeper
  import snake_pkg::X_W, snake_pkg::Y_W;
#(
  parameter int SCREEN_W = snake_pkg::SCREEN_W,
  parameter int SCREEN_H = snake_pkg::SCREEN_H
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start_i,
  input  logic           step_i,
  output logic [X_W-1:0] x_nxt_o,
  output logic [Y_W-1:0] y_nxt_o,
  output logic           done_o
);

  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           x_wrap;

  assign x_wrap  = (x_q == X_W'(SCREEN_W - 1));
  assign x_nxt_o = x_wrap ? '0 : x_q + X_W'(1);
  assign y_nxt_o = x_wrap ? y_q + Y_W'(1) : y_q;
  assign done_o  = x_wrap && (y_q == Y_W'(SCREEN_H - 1));

  // NOTE: reset is tested inside the clocked block, so it only acts on a clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (start_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (step_i) begin
      x_q <= x_nxt_o;
      y_q <= y_nxt_o;
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port between pixel producers.
// Define PLOT_ARB_CLEAR_EN to build in the full-screen sweeper (CLEAR state).
module vga_plot_arbiter
  import snake_pkg::X_W, snake_pkg::Y_W, snake_pkg::COL_W, snake_pkg::plot_state_e,
         snake_pkg::ARB, snake_pkg::CLEAR, snake_pkg::next_port;
#(
  parameter int NREQ     = 3,
  parameter int SCREEN_W = snake_pkg::SCREEN_W,
  parameter int SCREEN_H = snake_pkg::SCREEN_H
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*X_W-1:0]   x_in,
  input  logic [NREQ*Y_W-1:0]   y_in,
  input  logic [NREQ*COL_W-1:0] colour_in,
  output logic [NREQ-1:0]       gnt,
  input  logic                  clear_req,
  input  logic [COL_W-1:0]      clear_colour,
  output logic                  clear_busy,
  output logic [X_W-1:0]        x_out,
  output logic [Y_W-1:0]        y_out,
  output logic [COL_W-1:0]      colour_out,
  output logic                  plot
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  plot_state_e      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] col_q, col_d;

  logic [NREQ-1:0]  elig;
  logic             sel_vld;
  int               sel_idx;
  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [COL_W-1:0] sel_col;

  logic             clear_go;
  logic             sweep_start;
  logic             sweep_step;
  logic             sweep_done;
  logic [X_W-1:0]   sweep_x_nxt;
  logic [Y_W-1:0]   sweep_y_nxt;

`ifdef PLOT_ARB_CLEAR_EN
  assign clear_go = clear_req;

  screen_clear_sweeper #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweeper (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (sweep_start),
    .step_i  (sweep_step),
    .x_nxt_o (sweep_x_nxt),
    .y_nxt_o (sweep_y_nxt),
    .done_o  (sweep_done)
  );
`else
  logic unused_clear;

  assign clear_go     = 1'b0;
  assign sweep_done   = 1'b0;
  assign sweep_x_nxt  = '0;
  assign sweep_y_nxt  = '0;
  assign unused_clear = ^{clear_req, sweep_start, sweep_step};
`endif

  // The port shown this cycle sits out the next decision, so a held request
  // can never be granted twice for the same pixel.
  assign elig = req & ~gnt_q;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = 0;
    for (int off = 0; off < NREQ; off++) begin
      int cand;
      cand = int'(ptr_q) + off;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!sel_vld && elig[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign sel_x   = x_in[sel_idx*X_W +: X_W];
  assign sel_y   = y_in[sel_idx*Y_W +: Y_W];
  assign sel_col = colour_in[sel_idx*COL_W +: COL_W];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = '0;
    plot_d      = 1'b0;
    busy_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    col_d       = col_q;
    sweep_start = 1'b0;
    sweep_step  = 1'b0;

    case (state_q)
      ARB: begin
        if (clear_go) begin
          state_d     = CLEAR;
          sweep_start = 1'b1;
          busy_d      = 1'b1;
          plot_d      = 1'b1;
          x_d         = '0;
          y_d         = '0;
          col_d       = clear_colour;
        end else if (sel_vld) begin
          gnt_d[sel_idx] = 1'b1;
          x_d            = sel_x;
          y_d            = sel_y;
          col_d          = sel_col;
          // Off-screen pixels still consume their grant but never strobe the adapter.
          plot_d         = (sel_x < X_W'(SCREEN_W)) && (sel_y < Y_W'(SCREEN_H));
          ptr_d          = PTR_W'(next_port(sel_idx, NREQ));
        end
      end
      CLEAR: begin
        if (sweep_done) begin
          state_d = ARB;
        end else begin
          sweep_step = 1'b1;
          busy_d     = 1'b1;
          plot_d     = 1'b1;
          x_d        = sweep_x_nxt;
          y_d        = sweep_y_nxt;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      gnt_q   <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      plot_q  <= plot_d;
      busy_q  <= busy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
    end
  end

  assign gnt        = gnt_q;
  assign plot       = plot_q;
  assign clear_busy = busy_q;
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign colour_out = col_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: pixel-index reference model compared
// every cycle, directed literal checks, then randomized requesters.
module tb_vga_plot_arbiter;

  localparam int N    = 3;
  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;
`ifdef PLOT_ARB_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req;
  logic [N*8-1:0] x_in;
  logic [N*7-1:0] y_in;
  logic [N*3-1:0] colour_in;
  logic [N-1:0] gnt;
  logic         clear_req;
  logic [2:0]   clear_colour;
  logic         clear_busy;
  logic [7:0]   x_out;
  logic [6:0]   y_out;
  logic [2:0]   colour_out;
  logic         plot;

  always #5 clk = ~clk;

  vga_plot_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .x_in         (x_in),
    .y_in         (y_in),
    .colour_in    (colour_in),
    .gnt          (gnt),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .x_out        (x_out),
    .y_out        (y_out),
    .colour_out   (colour_out),
    .plot         (plot)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: sweep position kept as a flat pixel index.
  logic [N-1:0] e_gnt;
  logic         e_plot, e_busy;
  logic [7:0]   e_x;
  logic [6:0]   e_y;
  logic [2:0]   e_col;
  int           m_ptr, m_idx;
  bit           m_sweep;

  task automatic model_step();
    logic [N-1:0] avail;
    bit           found;
    int           g;
    if (!reset_n) begin
      m_sweep = 0; m_ptr = 0; m_idx = 0;
      e_gnt = '0; e_plot = 0; e_busy = 0; e_x = '0; e_y = '0; e_col = '0;
    end else if (m_sweep) begin
      e_gnt = '0;
      if (m_idx == NPIX - 1) begin
        m_sweep = 0; e_plot = 0; e_busy = 0;
      end else begin
        m_idx++;
        e_x = 8'(m_idx % W); e_y = 7'(m_idx / W); e_plot = 1; e_busy = 1;
      end
    end else if (CLEAR_EN && clear_req) begin
      m_sweep = 1; m_idx = 0;
      e_gnt = '0; e_x = '0; e_y = '0; e_col = clear_colour; e_plot = 1; e_busy = 1;
    end else begin
      avail = req & ~e_gnt;
      found = 0; g = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && avail[(m_ptr + k) % N]) begin
          found = 1; g = (m_ptr + k) % N;
        end
      end
      e_busy = 0;
      if (found) begin
        e_gnt  = N'(1 << g);
        e_x    = x_in[g*8 +: 8];
        e_y    = y_in[g*7 +: 7];
        e_col  = colour_in[g*3 +: 3];
        e_plot = (int'(e_x) < W) && (int'(e_y) < H);
        m_ptr  = (g + 1) % N;
      end else begin
        e_gnt  = '0;
        e_plot = 0;
      end
    end
  endtask

  always @(posedge clk) model_step();

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en)
      check("outputs", {9'd0, gnt, plot, clear_busy, x_out, y_out, colour_out},
                       {9'd0, e_gnt, e_plot, e_busy, e_x, e_y, e_col});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    x_in[p*8 +: 8]      = x;
    y_in[p*7 +: 7]      = y;
    colour_in[p*3 +: 3] = c;
  endtask

  task automatic new_pixel(input int p);
    set_port(p, 8'($urandom_range(175, 0)), 7'($urandom_range(127, 0)), 3'($urandom));
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req       = '0;
    clear_req = 1'b0;
    tick();
    reset_n   = 1'b1;
  endtask

  int cnt [N];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req = '0; clear_req = 1'b0; clear_colour = '0;
    x_in = '0; y_in = '0; colour_in = '0;
    tick();
    cmp_en = 1;

    // Reset state
    check("rst_gnt",  32'(gnt), 0);
    check("rst_plot", 32'(plot), 0);
    check("rst_busy", 32'(clear_busy), 0);
    check("rst_xyc",  {9'd0, x_out, y_out, colour_out, 5'd0}, 0);
    reset_n = 1'b1;

    // Single port: grant next cycle, then every other cycle
    set_port(1, 8'd10, 7'd20, 3'b100);
    req = 3'b010;
    tick();
    check("sp_gnt",  32'(gnt), 32'b010);
    check("sp_plot", 32'(plot), 1);
    check("sp_data", {14'd0, x_out, y_out, colour_out}, {14'd0, 8'd10, 7'd20, 3'b100});
    tick();
    check("sp_gap",  {30'd0, gnt[1], plot}, 0);
    tick();
    check("sp_gnt2", 32'(gnt), 32'b010);
    req = '0;
    tick();

    // Fairness: all ports continuously requesting
    do_reset();
    for (int p = 0; p < N; p++) set_port(p, 8'(p + 1), 7'(p + 2), 3'(p + 3));
    req = 3'b111;
    foreach (cnt[p]) cnt[p] = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      check("fair_gnt",  32'(gnt), 32'(1 << (c % 3)));
      check("fair_plot", 32'(plot), 1);
      for (int p = 0; p < N; p++) if (gnt[p]) cnt[p]++;
    end
    req = '0;
    tick();
    for (int p = 0; p < N; p++) check("fair_cnt", 32'(cnt[p]), 4);

    // Out-of-range pixel is granted but not plotted
    do_reset();
    set_port(0, 8'd160, 7'd5, 3'b001);
    req = 3'b001;
    tick();
    check("oor_gnt",  32'(gnt), 32'b001);
    check("oor_plot", 32'(plot), 0);
    set_port(0, 8'd159, 7'd119, 3'b010);
    tick();
    check("oor_gap", 32'(gnt), 0);
    tick();
    check("edge_gnt",  32'(gnt), 32'b001);
    check("edge_plot", 32'(plot), 1);
    check("edge_xy",   {17'd0, x_out, y_out}, {17'd0, 8'd159, 7'd119});
    req = '0;
    tick();

    // Sweep with port 2 pending
    do_reset();
    set_port(2, 8'd7, 7'd8, 3'd3);
    req = 3'b100; clear_req = 1'b1; clear_colour = 3'b000;
    tick();
`ifdef PLOT_ARB_CLEAR_EN
    check("sw_first", {18'd0, gnt, plot, clear_busy, x_out, y_out}, {18'd0, 3'b000, 1'b1, 1'b1, 8'd0, 7'd0});
`else
    check("nosw_gnt", {17'd0, gnt, clear_busy, x_out, y_out, colour_out}, {17'd0, 3'b100, 1'b0, 8'd7, 7'd8, 3'd3});
`endif
    for (int cyc = 2; cyc <= NPIX + 2; cyc++) begin
      if (cyc == 100) clear_req = 1'b0;
      tick();
`ifdef PLOT_ARB_CLEAR_EN
      if (cyc == 160) check("sw_row0_end", {17'd0, x_out, y_out}, {17'd0, 8'd159, 7'd0});
      if (cyc == 161) check("sw_row1_start", {17'd0, x_out, y_out}, {17'd0, 8'd0, 7'd1});
      if (cyc == NPIX) check("sw_last", {12'd0, gnt, plot, clear_busy, x_out, y_out, colour_out},
                             {12'd0, 3'b000, 1'b1, 1'b1, 8'd159, 7'd119, 3'b000});
      if (cyc == NPIX + 1) check("sw_busy_fall", {27'd0, gnt, plot, clear_busy}, 0);
      if (cyc == NPIX + 2) check("sw_resume", {14'd0, gnt, x_out, y_out, colour_out},
                                 {14'd0, 3'b100, 8'd7, 7'd8, 3'd3});
`endif
    end
    req = '0;
    tick();

    // Collision: clear and req[0] on the same edge
    do_reset();
    set_port(0, 8'd33, 7'd44, 3'd5);
    req = 3'b001; clear_req = 1'b1; clear_colour = 3'b110;
    tick();
    clear_req = 1'b0; clear_colour = 3'b001;
`ifdef PLOT_ARB_CLEAR_EN
    check("col_first", {25'd0, gnt, plot, colour_out}, {25'd0, 3'b000, 1'b1, 3'b110});
    for (int cyc = 2; cyc <= NPIX + 2; cyc++) begin
      tick();
      if (cyc == NPIX) check("col_latched", 32'(colour_out), 32'b110);
      if (cyc == NPIX + 2) check("col_resume", {14'd0, gnt, x_out, y_out, colour_out},
                                 {14'd0, 3'b001, 8'd33, 7'd44, 3'd5});
    end
`else
    check("nocol_gnt", {14'd0, gnt, x_out, y_out, colour_out}, {14'd0, 3'b001, 8'd33, 7'd44, 3'd5});
`endif
    req = '0;
    tick();

    // Reset in the middle of a sweep, pointer left at 1 beforehand
    do_reset();
    set_port(0, 8'd1, 7'd1, 3'd1);
    req = 3'b001;
    tick();
    req = '0; clear_req = 1'b1; clear_colour = 3'b111;
    tick();
    clear_req = 1'b0;
    repeat (500) tick();
`ifdef PLOT_ARB_CLEAR_EN
    check("rs_pix500", {17'd0, x_out, y_out}, {17'd0, 8'd20, 7'd3});
`endif
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rs_outs", {9'd0, gnt, plot, clear_busy, x_out, y_out, colour_out}, 0);
    set_port(0, 8'd50, 7'd60, 3'd2);
    set_port(1, 8'd51, 7'd61, 3'd4);
    req = 3'b011;
    tick();
    check("rs_ptr", 32'(gnt), 32'b001);
    req = '0;
    tick();

    // Randomized requesters obeying the hold-until-granted rule
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!req[p]) begin
          if ($urandom_range(1, 0) == 1) begin
            new_pixel(p);
            req[p] = 1'b1;
          end
        end else if (e_gnt[p]) begin
          if ($urandom_range(3, 0) == 0) req[p] = 1'b0;
          else new_pixel(p);
        end
      end
`ifndef PLOT_ARB_CLEAR_EN
      clear_req    = ($urandom_range(7, 0) == 0);
      clear_colour = 3'($urandom);
`endif
      reset_n = ($urandom_range(299, 0) != 0);
      tick();
    end
    reset_n = 1'b1; req = '0; clear_req = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
